// File: rtl/score_grader.sv
// Learning-mode grader: opens a timed window per expected note, counts hits,
// and converts the final hit ratio into a one-hot C/B/A/S grade for the display.
module score_grader #(
   parameter int unsigned WINDOW_CYCLES = 50_000_000,
   parameter int unsigned S_PCT         = 90,
   parameter int unsigned A_PCT         = 75,
   parameter int unsigned B_PCT         = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       note_valid,
   input  logic [6:0] note_expected,
   input  logic [6:0] key_pressed,
   input  logic       song_end,
   output logic [3:0] score,
   output logic       grade_valid,
   output logic       busy,
   output logic [7:0] hit_count,
   output logic [7:0] note_count
);

   localparam int unsigned     CNT_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_NOTE,
      ST_WINDOW,
      ST_GRADE,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      GR_C,
      GR_B,
      GR_A,
      GR_S
   } grade_t;

   state_t           state_q, state_d;
   grade_t           grade_q, grade_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       note_q, note_d;
   logic [7:0]       hit_count_q, hit_count_d;
   logic [7:0]       note_count_q, note_count_d;
   logic [3:0]       score_q, score_d;
   logic             grade_valid_q, grade_valid_d;
   logic             busy_q, busy_d;

   logic             key_match;
   logic             new_note;
   logic [14:0]      h100;
   logic [14:0]      n_s, n_a, n_b;
   grade_t           grade_calc;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] grade_onehot(input grade_t g);
      case (g)
         GR_S:    return 4'b1000;
         GR_A:    return 4'b0100;
         GR_B:    return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   // Ratio test done as cross-multiplication so no divider is needed.
   always_comb begin
      h100 = 15'(hit_count_q) * 15'd100;
      n_s  = 15'(note_count_q) * 15'(S_PCT);
      n_a  = 15'(note_count_q) * 15'(A_PCT);
      n_b  = 15'(note_count_q) * 15'(B_PCT);

      if (note_count_q == 8'd0) begin
         grade_calc = GR_C;
      end else if (h100 >= n_s) begin
         grade_calc = GR_S;
      end else if (h100 >= n_a) begin
         grade_calc = GR_A;
      end else if (h100 >= n_b) begin
         grade_calc = GR_B;
      end else begin
         grade_calc = GR_C;
      end
   end

   assign key_match = (key_pressed == note_q);
   assign new_note  = note_valid && (note_expected != 7'd0);

   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d       = state_q;
      grade_d       = grade_q;
      cnt_d         = cnt_q;
      note_d        = note_q;
      hit_count_d   = hit_count_q;
      note_count_d  = note_count_q;
      score_d       = score_q;
      grade_valid_d = grade_valid_q;
      busy_d        = busy_q;

      if (start) begin
         state_d       = ST_WAIT_NOTE;
         cnt_d         = '0;
         note_d        = 7'd0;
         hit_count_d   = 8'd0;
         note_count_d  = 8'd0;
         score_d       = 4'd0;
         grade_valid_d = 1'b0;
         busy_d        = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
            end

            ST_WAIT_NOTE: begin
               if (song_end) begin
                  state_d = ST_GRADE;
               end else if (new_note) begin
                  note_d       = note_expected;
                  note_count_d = sat_inc(note_count_q);
                  cnt_d        = '0;
                  state_d      = ST_WINDOW;
               end
            end

            ST_WINDOW: begin
               // The open note always resolves against this cycle's keys first.
               if (key_match) begin
                  hit_count_d = sat_inc(hit_count_q);
               end

               if (song_end) begin
                  state_d = ST_GRADE;
               end else if (note_valid) begin
                  if (new_note) begin
                     note_d       = note_expected;
                     note_count_d = sat_inc(note_count_q);
                     cnt_d        = '0;
                  end else begin
                     state_d = ST_WAIT_NOTE;
                  end
               end else if (key_match || (cnt_q == CNT_LAST)) begin
                  state_d = ST_WAIT_NOTE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_GRADE: begin
               grade_d = grade_calc;
               state_d = ST_DONE;
            end

            ST_DONE: begin
               score_d       = grade_onehot(grade_q);
               grade_valid_d = 1'b1;
               busy_d        = 1'b0;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         grade_q       <= GR_C;
         cnt_q         <= '0;
         note_q        <= 7'd0;
         hit_count_q   <= 8'd0;
         note_count_q  <= 8'd0;
         score_q       <= 4'd0;
         grade_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q       <= state_d;
         grade_q       <= grade_d;
         cnt_q         <= cnt_d;
         note_q        <= note_d;
         hit_count_q   <= hit_count_d;
         note_count_q  <= note_count_d;
         score_q       <= score_d;
         grade_valid_q <= grade_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign score       = score_q;
   assign grade_valid = grade_valid_q;
   assign busy        = busy_q;
   assign hit_count   = hit_count_q;
   assign note_count  = note_count_q;

endmodule

// File: tb/tb_score_grader.sv
// Randomized, scoreboard-checked bench for score_grader with a short hit window;
// a monitor compares every presented grade against the reference model's queue.
module tb_score_grader;

   localparam int WIN = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       note_valid;
   logic [6:0] note_expected;
   logic [6:0] key_pressed;
   logic       song_end;
   logic [3:0] score;
   logic       grade_valid;
   logic       busy;
   logic [7:0] hit_count;
   logic [7:0] note_count;

   typedef struct {
      logic [3:0] score;
      int         hits;
      int         notes;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic       gv_prev;
   int         checks = 0;
   int         errors = 0;
   int         m_hits;
   int         m_notes;
   logic [3:0] last_score;

   score_grader #(
      .WINDOW_CYCLES(WIN),
      .S_PCT        (90),
      .A_PCT        (75),
      .B_PCT        (50)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .note_valid   (note_valid),
      .note_expected(note_expected),
      .key_pressed  (key_pressed),
      .song_end     (song_end),
      .score        (score),
      .grade_valid  (grade_valid),
      .busy         (busy),
      .hit_count    (hit_count),
      .note_count   (note_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: a note is a hit iff the exact key was held on one of the
   // WIN sampled cycles following its presentation.
   function automatic bit note_is_hit(input logic [6:0] note, input int press_at, input logic [6:0] key);
      return (note != 7'd0) && (press_at >= 1) && (press_at <= WIN) && (key == note);
   endfunction

   function automatic logic [3:0] grade_of(input int hits, input int notes);
      if (notes == 0)                return 4'b0001;
      if (hits * 100 >= notes * 90)  return 4'b1000;
      if (hits * 100 >= notes * 75)  return 4'b0100;
      if (hits * 100 >= notes * 50)  return 4'b0010;
      return 4'b0001;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start   = 1'b0;
      m_hits  = 0;
      m_notes = 0;
   endtask

   // Presents one note, then holds key for a single cycle at sample press_at
   // (1 = first edge after the note edge; 0 = never pressed).
   task automatic play_note(input logic [6:0] note, input int press_at, input logic [6:0] key);
      note_valid    = 1'b1;
      note_expected = note;
      tick();
      note_valid    = 1'b0;
      note_expected = 7'd0;
      for (int k = 1; k <= WIN + 2; k++) begin
         key_pressed = (k == press_at) ? key : 7'd0;
         tick();
      end
      key_pressed = 7'd0;
      if (note != 7'd0) m_notes++;
      if (note_is_hit(note, press_at, key)) m_hits++;
   endtask

   task automatic finish_song();
      exp_t e;
      e.score    = grade_of(m_hits, m_notes);
      e.hits     = m_hits;
      e.notes    = m_notes;
      last_score = e.score;
      exp_q.push_back(e);
      song_end = 1'b1;
      tick();
      song_end = 1'b0;
      tick();
      @(negedge clk);
      check("grade_one_cycle_gv", 32'(grade_valid), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("grade_two_cycle_gv", 32'(grade_valid), 32'd1);
      check("grade_two_cycle_busy", 32'(busy), 32'd0);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         gv_prev = 1'b0;
      end else begin
         if (grade_valid && !gv_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grade: got score %b, expected no grade", score);
            end else begin
               mon_e = exp_q.pop_front();
               check("mon_score", 32'(score), 32'(mon_e.score));
               check("mon_hit_count", 32'(hit_count), 32'(mon_e.hits));
               check("mon_note_count", 32'(note_count), 32'(mon_e.notes));
            end
         end
         gv_prev = grade_valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [6:0] rnote;
      logic [6:0] rkey;
      int         rpress;
      int         nnotes;

      reset = 1'b1;
      start = 1'b0;
      note_valid = 1'b0;
      note_expected = 7'd0;
      key_pressed = 7'd0;
      song_end = 1'b0;
      m_hits = 0;
      m_notes = 0;
      last_score = 4'd0;
      #1;
      check("reset_outputs", 32'({score, grade_valid, busy, hit_count, note_count}), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // All ten notes hit -> S
      do_start();
      for (int i = 0; i < 10; i++) play_note(7'b0000001, 3, 7'b0000001);
      check("s_run_hits", 32'(hit_count), 32'd10);
      check("s_run_notes", 32'(note_count), 32'd10);
      finish_song();

      // song_end while DONE is ignored
      song_end = 1'b1;
      tick();
      song_end = 1'b0;
      tick();
      tick();
      check("done_song_end_score", 32'(score), 32'(last_score));
      check("done_song_end_gv", 32'(grade_valid), 32'd1);

      // 3 of 4 -> A; start out of DONE clears outputs
      do_start();
      check("start_clears", 32'({score, grade_valid, busy, hit_count, note_count}), 32'h0001_0000);
      play_note(7'b0001000, 2, 7'b0001000);
      play_note(7'b0001000, 0, 7'b0000000);
      check("miss_hits_unchanged", 32'(hit_count), 32'd1);
      play_note(7'b0100000, 5, 7'b0100000);
      play_note(7'b0000010, 1, 7'b0000010);
      finish_song();

      // 2 of 4 -> B
      do_start();
      play_note(7'b0000001, 4, 7'b0000001);
      play_note(7'b0000010, 0, 7'b0000000);
      play_note(7'b0000100, 6, 7'b0000100);
      play_note(7'b0001000, 0, 7'b0000000);
      finish_song();

      // 1 of 4 -> C
      do_start();
      play_note(7'b1000000, 7, 7'b1000000);
      for (int i = 0; i < 3; i++) play_note(7'b0010000, 0, 7'b0000000);
      finish_song();

      // No notes -> C
      do_start();
      finish_song();

      // Window boundaries, extra keys, rest notes
      do_start();
      play_note(7'b0000100, 8, 7'b0000100);
      check("edge8_hits", 32'(hit_count), 32'd1);
      play_note(7'b0000100, 9, 7'b0000100);
      check("edge9_hits", 32'(hit_count), 32'd1);
      check("edge9_notes", 32'(note_count), 32'd2);
      play_note(7'b0000100, 3, 7'b0000110);
      check("extra_key_hits", 32'(hit_count), 32'd1);
      play_note(7'b0000000, 2, 7'b0000000);
      check("rest_notes", 32'(note_count), 32'd3);
      finish_song();

      // New note arrives while previous window is still open
      do_start();
      note_valid = 1'b1;
      note_expected = 7'b0000010;
      tick();
      note_valid = 1'b0;
      note_expected = 7'd0;
      tick();
      tick();
      note_valid = 1'b1;
      note_expected = 7'b0010000;
      tick();
      note_valid = 1'b0;
      note_expected = 7'd0;
      for (int k = 1; k <= WIN + 2; k++) begin
         key_pressed = (k == WIN) ? 7'b0010000 : 7'd0;
         tick();
      end
      key_pressed = 7'd0;
      m_notes = 2;
      m_hits = 1;
      check("overlap_hits", 32'(hit_count), 32'd1);
      check("overlap_notes", 32'(note_count), 32'd2);
      finish_song();

      // start and song_end together: run restarts, no grade
      do_start();
      play_note(7'b0000001, 2, 7'b0000001);
      play_note(7'b0000001, 2, 7'b0000001);
      start = 1'b1;
      song_end = 1'b1;
      tick();
      start = 1'b0;
      song_end = 1'b0;
      m_hits = 0;
      m_notes = 0;
      tick();
      tick();
      tick();
      check("start_wins_state", 32'({grade_valid, busy, note_count}), 32'h100);
      play_note(7'b0000001, 2, 7'b0000001);
      finish_song();

      // Asynchronous reset mid-window
      do_start();
      for (int i = 0; i < 3; i++) play_note(7'b0000001, 2, 7'b0000001);
      note_valid = 1'b1;
      note_expected = 7'b1000000;
      tick();
      note_valid = 1'b0;
      note_expected = 7'd0;
      tick();
      check("pre_reset_hits", 32'(hit_count), 32'd3);
      reset = 1'b1;
      #1;
      check("async_reset_outputs", 32'({score, grade_valid, busy, hit_count, note_count}), 32'd0);
      tick();
      reset = 1'b0;
      note_valid = 1'b1;
      note_expected = 7'b0000001;
      key_pressed = 7'b0000001;
      tick();
      note_valid = 1'b0;
      note_expected = 7'd0;
      tick();
      key_pressed = 7'd0;
      check("idle_ignores_notes", 32'({busy, hit_count, note_count}), 32'd0);
      do_start();
      finish_song();

      // Randomized play-throughs
      for (int r = 0; r < 25; r++) begin
         do_start();
         nnotes = $urandom_range(0, 12);
         for (int i = 0; i < nnotes; i++) begin
            rnote  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'(1 << $urandom_range(0, 6));
            rpress = $urandom_range(0, WIN + 2);
            rkey   = ($urandom_range(0, 3) == 0) ? (rnote | 7'(1 << $urandom_range(0, 6))) : rnote;
            play_note(rnote, rpress, rkey);
         end
         finish_song();
      end

      for (int i = 0; i < 5; i++) tick();
      check("pending_grades", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_grader.md
Name: score_grader

Overview:
- Upstream stage of the seven-segment display driver. Grades one learning-mode play-through of a song.
- Opens a timing window for every expected note and checks whether the player pressed the matching key inside it.
- Counts hits and notes; at song end, converts the hit ratio to a one-hot grade (C/B/A/S) on `score[3:0]`, which the display consumes directly.
- Sits between the song/note sequencer (sources `note_valid`, `note_expected`, `song_end`) and the display driver.

Parameters:
- `WINDOW_CYCLES`, 50000000: length of the hit window in clk cycles (0.5 s at 100 MHz). Benches use 8.
- `S_PCT`, 90: minimum hit percentage for grade S.
- `A_PCT`, 75: minimum hit percentage for grade A.
- `B_PCT`, 50: minimum hit percentage for grade B.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a new play-through.
- `note_valid`  in  1  one-cycle pulse; a new expected note is presented.
- `note_expected`  in  7  one-hot expected key; 0 = rest.
- `key_pressed`  in  7  debounced key levels from the keyboard.
- `song_end`  in  1  one-cycle pulse; the song has finished.
- `score`  out  4  one-hot grade: 0001 = C, 0010 = B, 0100 = A, 1000 = S, 0000 = none.
- `grade_valid`  out  1  high while `score` holds a final grade.
- `busy`  out  1  high from `start` until grading completes.
- `hit_count`  out  8  notes hit this run.
- `note_count`  out  8  non-rest notes presented this run.

Behaviour:
- Reset (async, active-high): FSM=IDLE; `score`=0, `grade_valid`=0, `busy`=0, `hit_count`=0, `note_count`=0, window counter=0, expected-note register=0. Reset mid-run discards the run completely.
- States:
  - IDLE: only `start` is acted on.
  - WAIT_NOTE: waiting for the next note.
  - WINDOW: a note window is open.
  - GRADE: one cycle.
  - DONE: grade is held.
- `start` (any state, highest priority): clear counts, `score`=0, `grade_valid`=0, `busy`=1, go to WAIT_NOTE next cycle. `start` together with `song_end` or `note_valid` in the same cycle: `start` wins and the other pulse is ignored.
- WAIT_NOTE + `note_valid`:
  - Rest (`note_expected`=0): ignored, not counted.
  - Otherwise: latch `note_expected`, `note_count`+1 (saturates at 255), counter=0, go to WINDOW.
- WINDOW, evaluated every cycle:
  - Match: `key_pressed` == latched note, exact 7-bit equality, so extra keys are a miss.
  - Match: `hit_count`+1 (saturates at 255), go to WAIT_NOTE. Only one hit per note.
  - No match and counter == `WINDOW_CYCLES`-1: miss, go to WAIT_NOTE.
  - Otherwise: counter+1.
  - Effective window: the `WINDOW_CYCLES` cycles starting the cycle after `note_valid`.
- `note_valid` while in WINDOW: the current note resolves this cycle (hit if it matches this cycle, else miss). A non-rest new note is then latched and counted, counter=0, and the FSM stays in WINDOW. A rest note returns the FSM to WAIT_NOTE.
- `song_end` in WAIT_NOTE or WINDOW: the current note resolves as above, then go to GRADE. `song_end` in IDLE or DONE is ignored.
- GRADE, registered comparisons (widths and values):
  - h100 = `hit_count`*100 (15 bits); compare against `note_count`*PCT (15 bits).
  - h100 >= n*`S_PCT` → S.
  - else h100 >= n*`A_PCT` → A.
  - else h100 >= n*`B_PCT` → B.
  - else → C.
  - `note_count`=0 → C.
- GRADE → DONE: `score`, `grade_valid`=1 and `busy`=0 appear 2 cycles after the `song_end` sample edge. DONE holds all values until `start` or `reset`.
- `score` is 0 everywhere except DONE. `hit_count` and `note_count` stay readable in DONE.

Test Plan (`WINDOW_CYCLES`=8):
- Reset asserted mid-WINDOW with `hit_count`=3 → all outputs 0 immediately (asynchronous), FSM IDLE. The next `start` is needed to run.
- `start`; 10 notes (0000001), each matched 3 cycles after `note_valid`; `song_end` → `hit_count`=10, `note_count`=10. Two cycles later `score`=1000 (S), `grade_valid`=1, `busy`=0.
- 4 notes, 3 hit, 1 never pressed (75%) → `score`=0100 (A). The missed note resolves after exactly 8 cycles with no count change.
- 4 notes, 2 hit (50%) → 0010 (B). 4 notes, 1 hit (25%) → 0001 (C). `start` then `song_end` with no notes → 0001 (C).
- Window boundary:
  - Key 0000100 matched at window cycle 8 → hit.
  - Match at cycle 9 → miss.
  - `key_pressed`=0000110 for expected 0000100 → miss.
  - Rest note (0) → `note_count` unchanged.
- Simultaneous events:
  - `note_valid` arrives while the previous window still has no match → previous note is a miss, new note is counted, window restarts.
  - `start` and `song_end` in the same cycle → run restarts, no grade produced.
  - `song_end` in DONE → ignored, `score` held.
